// File: rtl/quad_step_ctrl.sv
// Quadrature encoder front end: synchronises and debounces SIA/SIB, then decodes
// the Gray sequence into one-cycle STEP pulses with a DIR qualifier.
module quad_step_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 3,
    parameter int DETENT    = 4
) (
    input  logic       CLK,
    input  logic       SW,
    input  logic       SIA,
    input  logic       SIB,
    input  logic       CLR_ERR,
    output logic       STEP,
    output logic       DIR,
    output logic       ERR,
    output logic [1:0] PHASE
);

    typedef enum logic {
        INIT,
        TRACK
    } state_t;

    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic signed [3:0] ACC_POS = 4'(DETENT);
    localparam logic signed [3:0] ACC_NEG = -ACC_POS;

    state_t                state_q, state_d;
    logic [1:0]            syncA_q, syncA_d;
    logic [1:0]            syncB_q, syncB_d;
    logic [1:0]            prevPair_q, prevPair_d;
    logic [DB_W-1:0]       initCnt_q, initCnt_d;
    logic [DB_W-1:0]       cntA_q, cntA_d;
    logic [DB_W-1:0]       cntB_q, cntB_d;
    logic [1:0]            phase_q, phase_d;
    logic signed [3:0]     acc_q, acc_d;
    logic                  step_q, step_d;
    logic                  dir_q, dir_d;
    logic                  err_q, err_d;

    logic [1:0]            pair;
    logic                  newA, newB;
    logic [1:0]            phaseChange;
    logic [1:0]            posNext;
    logic                  atLimit;
    logic signed [3:0]     accBase;

    // Position of each debounced state along the forward Gray sequence 00->10->11->01
    function automatic logic [1:0] grayPos(input logic [1:0] p);
        case (p)
            2'b00:   grayPos = 2'd0;
            2'b10:   grayPos = 2'd1;
            2'b11:   grayPos = 2'd2;
            default: grayPos = 2'd3;
        endcase
    endfunction

    assign pair = {syncA_q[1], syncB_q[1]};

    always_comb begin
        syncA_d     = {syncA_q[0], SIA};
        syncB_d     = {syncB_q[0], SIB};
        prevPair_d  = pair;
        state_d     = state_q;
        initCnt_d   = initCnt_q;
        cntA_d      = cntA_q;
        cntB_d      = cntB_q;
        phase_d     = phase_q;
        acc_d       = acc_q;
        step_d      = 1'b0;
        dir_d       = dir_q;
        err_d       = CLR_ERR ? 1'b0 : err_q;
        newA        = phase_q[1];
        newB        = phase_q[0];
        phaseChange = 2'b00;
        posNext     = grayPos(phase_q) + 2'd1;
        atLimit     = (acc_q == ACC_POS) || (acc_q == ACC_NEG);
        accBase     = atLimit ? 4'sd0 : acc_q;

        case (state_q)
            INIT: begin
                if (pair != prevPair_q) begin
                    initCnt_d = '0;
                end else if (initCnt_q >= DB_LAST) begin
                    phase_d   = pair;
                    state_d   = TRACK;
                    initCnt_d = '0;
                    cntA_d    = '0;
                    cntB_d    = '0;
                    acc_d     = 4'sd0;
                end else begin
                    initCnt_d = initCnt_q + DB_W'(1);
                end
            end

            TRACK: begin
                if (pair[1] != phase_q[1]) begin
                    if (cntA_q >= DB_LAST) begin
                        newA   = pair[1];
                        cntA_d = '0;
                    end else begin
                        cntA_d = cntA_q + DB_W'(1);
                    end
                end else begin
                    cntA_d = '0;
                end

                if (pair[0] != phase_q[0]) begin
                    if (cntB_q >= DB_LAST) begin
                        newB   = pair[0];
                        cntB_d = '0;
                    end else begin
                        cntB_d = cntB_q + DB_W'(1);
                    end
                end else begin
                    cntB_d = '0;
                end

                phase_d     = {newA, newB};
                phaseChange = phase_d ^ phase_q;

                // A full detent reached last cycle is paid out now as a single STEP
                if (atLimit) begin
                    step_d = 1'b1;
                    dir_d  = (acc_q == ACC_NEG);
                end

                acc_d = accBase;
                if (phaseChange == 2'b11) begin
                    err_d = 1'b1;
                    acc_d = 4'sd0;
                end else if (phaseChange != 2'b00) begin
                    acc_d = (grayPos(phase_d) == posNext) ? accBase + 4'sd1
                                                          : accBase - 4'sd1;
                end
            end

            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!SW) begin
            state_q    <= INIT;
            syncA_q    <= 2'b00;
            syncB_q    <= 2'b00;
            prevPair_q <= 2'b00;
            initCnt_q  <= '0;
            cntA_q     <= '0;
            cntB_q     <= '0;
            phase_q    <= 2'b00;
            acc_q      <= 4'sd0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            syncA_q    <= syncA_d;
            syncB_q    <= syncB_d;
            prevPair_q <= prevPair_d;
            initCnt_q  <= initCnt_d;
            cntA_q     <= cntA_d;
            cntB_q     <= cntB_d;
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign STEP  = step_q;
    assign DIR   = dir_q;
    assign ERR   = err_q;
    assign PHASE = phase_q;

endmodule

// File: tb/tb_quad_step_ctrl.sv
// Directed bench for quad_step_ctrl: reset/init, full detents both ways, bounce
// filtering, illegal jumps with CLR_ERR priority, and partial detents across reset.
module tb_quad_step_ctrl;

    logic       CLK = 1'b0;
    logic       SW = 1'b0;
    logic       SIA = 1'b0;
    logic       SIB = 1'b0;
    logic       CLR_ERR = 1'b0;
    logic       STEP;
    logic       DIR;
    logic       ERR;
    logic [1:0] PHASE;

    int checks = 0;
    int failures = 0;
    int stepCount = 0;
    int base = 0;

    quad_step_ctrl #(
        .DB_CYCLES(4),
        .DB_W(3),
        .DETENT(4)
    ) dut (
        .CLK(CLK),
        .SW(SW),
        .SIA(SIA),
        .SIB(SIB),
        .CLR_ERR(CLR_ERR),
        .STEP(STEP),
        .DIR(DIR),
        .ERR(ERR),
        .PHASE(PHASE)
    );

    always #5 CLK = ~CLK;

    // Independent tally of every STEP pulse the DUT emits
    always @(posedge CLK) begin
        if (STEP === 1'b1) stepCount <= stepCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive {A,B} right after a falling edge, then wait n falling edges
    task automatic applyStimulus(input logic a, input logic b, input int n);
        SIA = a;
        SIB = b;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);

        // Reset with both channels high, then let INIT settle on 11
        SW = 1'b0;
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("rst_step", 32'(STEP), 32'd0);
        checkOutput("rst_dir", 32'(DIR), 32'd0);
        checkOutput("rst_err", 32'(ERR), 32'd0);
        checkOutput("rst_phase", 32'(PHASE), 32'd0);
        SW = 1'b1;
        repeat (4) @(negedge CLK);
        checkOutput("init_wait_phase", 32'(PHASE), 32'd0);
        repeat (6) @(negedge CLK);
        checkOutput("init_phase11", 32'(PHASE), 32'd3);
        checkOutput("init_no_step", 32'(stepCount), 32'd0);
        checkOutput("init_no_err", 32'(ERR), 32'd0);

        // Re-initialise on 00 as the starting point for the detent tests
        SW = 1'b0;
        applyStimulus(1'b0, 1'b0, 2);
        SW = 1'b1;
        repeat (12) @(negedge CLK);
        checkOutput("init_phase00", 32'(PHASE), 32'd0);

        // Forward detent
        base = stepCount;
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("fwd_no_early_step", 32'(stepCount - base), 32'd0);
        applyStimulus(1'b0, 1'b0, 6);
        checkOutput("fwd_phase_back00", 32'(PHASE), 32'd0);
        checkOutput("fwd_step_not_yet", 32'(STEP), 32'd0);
        @(negedge CLK);
        checkOutput("fwd_step", 32'(STEP), 32'd1);
        checkOutput("fwd_dir", 32'(DIR), 32'd0);
        @(negedge CLK);
        checkOutput("fwd_step_one_cycle", 32'(STEP), 32'd0);
        repeat (8) @(negedge CLK);
        checkOutput("fwd_step_count", 32'(stepCount - base), 32'd1);
        checkOutput("fwd_no_err", 32'(ERR), 32'd0);

        // Reverse detent
        base = stepCount;
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 7);
        checkOutput("rev_step", 32'(STEP), 32'd1);
        checkOutput("rev_dir", 32'(DIR), 32'd1);
        repeat (20) @(negedge CLK);
        checkOutput("rev_dir_held", 32'(DIR), 32'd1);
        checkOutput("rev_step_count", 32'(stepCount - base), 32'd1);

        // Bounce on A: 3 high / 2 low never survives the filter
        base = stepCount;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 3);
            applyStimulus(1'b0, 1'b0, 2);
        end
        checkOutput("bounce_phase", 32'(PHASE), 32'd0);
        applyStimulus(1'b1, 1'b0, 5);
        checkOutput("bounce_latency_5", 32'(PHASE), 32'd0);
        @(negedge CLK);
        checkOutput("bounce_latency_6", 32'(PHASE), 32'd2);
        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("bounce_restore", 32'(PHASE), 32'd0);
        checkOutput("bounce_no_step", 32'(stepCount - base), 32'd0);

        // Illegal jumps and CLR_ERR priority
        base = stepCount;
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput("ill_err_set", 32'(ERR), 32'd1);
        checkOutput("ill_phase", 32'(PHASE), 32'd3);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        checkOutput("ill_err_cleared", 32'(ERR), 32'd0);
        applyStimulus(1'b0, 1'b0, 5);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        checkOutput("ill_set_wins", 32'(ERR), 32'd1);
        checkOutput("ill_phase00", 32'(PHASE), 32'd0);
        repeat (3) @(negedge CLK);
        checkOutput("ill_err_sticky", 32'(ERR), 32'd1);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        checkOutput("ill_err_cleared2", 32'(ERR), 32'd0);
        checkOutput("ill_no_step", 32'(stepCount - base), 32'd0);

        // Partial detent: two forward then two reverse
        base = stepCount;
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("part_no_step", 32'(stepCount - base), 32'd0);
        checkOutput("part_phase", 32'(PHASE), 32'd0);

        // Two forward, then a one-cycle reset must discard the progress
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
        SW = 1'b0;
        @(negedge CLK);
        checkOutput("midrst_phase", 32'(PHASE), 32'd0);
        checkOutput("midrst_dir", 32'(DIR), 32'd0);
        SW = 1'b1;
        repeat (15) @(negedge CLK);
        checkOutput("midrst_reinit", 32'(PHASE), 32'd3);
        base = stepCount;
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("midrst_no_early_step", 32'(stepCount - base), 32'd0);
        applyStimulus(1'b1, 1'b1, 7);
        checkOutput("midrst_step", 32'(STEP), 32'd1);
        checkOutput("midrst_step_dir", 32'(DIR), 32'd0);
        repeat (5) @(negedge CLK);
        checkOutput("midrst_step_count", 32'(stepCount - base), 32'd1);
        checkOutput("final_no_err", 32'(ERR), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
